rgb_line_sync: RTL and testbench

//  Single-clock, parametrised line buffer and frame tracker for the camera pixel stream.

---
 rtl/rgb_line_sync.sv | 137 +++++++++++++
 tb/tb_rgb_line_sync.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_line_sync.sv
// Frame/line tracker and first-word-fall-through pixel FIFO for the camera stream.
// Skips leading lines, tags SOF/SOL, pulses resync periodically and keeps sticky error flags.
module rgb_line_sync #(
    parameter int PIX_W         = 24,
    parameter int DEPTH         = 2048,
    parameter int LINE_W        = 11,
    parameter int FRAME_W       = 6,
    parameter int SKIP_LINES    = 3,
    parameter int RESYNC_FRAMES = 60
) (
    input  logic                     csi_clk,
    input  logic                     reset,
    input  logic                     csi_in_frame,
    input  logic                     csi_in_line,
    input  logic [PIX_W-1:0]         in_pix,
    input  logic                     in_valid,
    output logic [PIX_W-1:0]         out_pix,
    output logic                     out_sof,
    output logic                     out_sol,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     resync_n,
    output logic [LINE_W-1:0]        line_count,
    output logic [FRAME_W-1:0]       frame_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf_sticky,
    output logic                     udf_sticky,
    input  logic                     clr_sticky,
    output logic [1:0]               state
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SKIP       = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    state_t           cur_state;
    logic             frame_q, line_q;
    logic             seen_frame, sof_pend, sol_pend;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [PIX_W+1:0] mem [DEPTH];

    logic               frame_rise, frame_fall, line_rise;
    logic               full, pop, can_write, push, drop, underflow;
    logic               resync_fire, sol_tag;
    logic [FRAME_W-1:0] next_frame;

    assign fifo_level                 = wr_ptr - rd_ptr;
    assign out_valid                  = (fifo_level != '0);
    assign {out_sof, out_sol, out_pix} = mem[rd_ptr[AW-1:0]];
    assign state                      = cur_state;

    always_comb begin
        frame_rise = csi_in_frame & ~frame_q;
        frame_fall = ~csi_in_frame & frame_q;
        line_rise  = csi_in_line & ~line_q & csi_in_frame;
        full       = (fifo_level == (AW+1)'(DEPTH));
        // A flush on frame rise overrides any same-cycle pop or push.
        pop        = out_valid & out_ready & ~frame_rise;
        can_write  = in_valid & csi_in_frame & (cur_state == ACTIVE) & ~frame_rise;
        push       = can_write & (~full | pop);
        drop       = can_write & full & ~pop;
        underflow  = out_ready & ~out_valid & (cur_state == ACTIVE) & csi_in_line;
        sol_tag    = sof_pend | sol_pend | line_rise;

        if (!seen_frame)
            next_frame = '0;
        else if ((RESYNC_FRAMES != 0) && (frame_count == FRAME_W'(RESYNC_FRAMES - 1)))
            next_frame = '0;
        else
            next_frame = frame_count + 1'b1;

        resync_fire = frame_rise & (~seen_frame | ((RESYNC_FRAMES != 0) & (next_frame == '0)));
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone decide what is valid.
    always_ff @(posedge csi_clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {sof_pend, sol_tag, in_pix};
    end

    always_ff @(posedge csi_clk) begin
        if (reset) begin
            frame_q     <= 1'b0;
            line_q      <= 1'b0;
            seen_frame  <= 1'b0;
            sof_pend    <= 1'b0;
            sol_pend    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cur_state   <= WAIT_FRAME;
            line_count  <= '0;
            frame_count <= '0;
            resync_n    <= 1'b1;
            ovf_sticky  <= 1'b0;
            udf_sticky  <= 1'b0;
        end else begin
            frame_q    <= csi_in_frame;
            line_q     <= csi_in_line;
            resync_n   <= ~resync_fire;
            ovf_sticky <= drop | (ovf_sticky & ~clr_sticky);
            udf_sticky <= underflow | (udf_sticky & ~clr_sticky);

            if (frame_rise) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                seen_frame  <= 1'b1;
                frame_count <= next_frame;
                line_count  <= LINE_W'(line_rise);
                sof_pend    <= 1'b1;
                sol_pend    <= 1'b1;
                cur_state   <= (SKIP_LINES == 0) ? ACTIVE : SKIP;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;

                if (push) begin
                    sof_pend <= 1'b0;
                    sol_pend <= 1'b0;
                end else if (line_rise) begin
                    sol_pend <= 1'b1;
                end

                if (line_rise && (line_count != '1))
                    line_count <= line_count + 1'b1;

                // Leave SKIP on the rise that opens the first line past the skipped ones.
                if (frame_fall)
                    cur_state <= WAIT_FRAME;
                else if ((cur_state == SKIP) && line_rise && (line_count >= LINE_W'(SKIP_LINES)))
                    cur_state <= ACTIVE;
            end
        end
    end
endmodule

// File: tb/tb_rgb_line_sync.sv
// Self-checking bench for rgb_line_sync: cycle table, directed corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_rgb_line_sync;
    localparam int PIX_W  = 24;
    localparam int DEPTH  = 16;
    localparam int LINE_W = 11;
    localparam int FRAME_W = 6;
    localparam int SKIPN  = 3;
    localparam int RESYNC = 3;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset, frame, line, valid, ready, clr;
    logic [PIX_W-1:0]   pix;
    logic [PIX_W-1:0]   out_pix;
    logic               out_sof, out_sol, out_valid, resync_n, ovf_sticky, udf_sticky;
    logic [LINE_W-1:0]  line_count;
    logic [FRAME_W-1:0] frame_count;
    logic [LW-1:0]      fifo_level;
    logic [1:0]         state;

    always #5 clk = ~clk;

    rgb_line_sync #(
        .PIX_W(PIX_W), .DEPTH(DEPTH), .LINE_W(LINE_W), .FRAME_W(FRAME_W),
        .SKIP_LINES(SKIPN), .RESYNC_FRAMES(RESYNC)
    ) dut (
        .csi_clk(clk), .reset(reset), .csi_in_frame(frame), .csi_in_line(line),
        .in_pix(pix), .in_valid(valid), .out_pix(out_pix), .out_sof(out_sof),
        .out_sol(out_sol), .out_valid(out_valid), .out_ready(ready), .resync_n(resync_n),
        .line_count(line_count), .frame_count(frame_count), .fifo_level(fifo_level),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky), .clr_sticky(clr), .state(state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, counters as plain integers.
    typedef struct packed {
        logic             sof;
        logic             sol;
        logic [PIX_W-1:0] pix;
    } ent_t;

    ent_t mq[$];
    ent_t got[$];
    int   m_state, m_lines, m_frame;
    bit   m_seen, m_fq, m_lq, m_sof_pend, m_sol_pend, m_ovf, m_udf, m_resync_n;

    task automatic model_reset();
        mq.delete();
        m_state = 0; m_lines = 0; m_frame = 0;
        m_seen = 0; m_fq = 0; m_lq = 0; m_sof_pend = 0; m_sol_pend = 0;
        m_ovf = 0; m_udf = 0; m_resync_n = 1;
    endtask

    task automatic model_step();
        bit   fr, ff, lr, pop, want, pushed;
        ent_t e;
        if (reset) begin
            model_reset();
            return;
        end
        fr     = frame && !m_fq;
        ff     = !frame && m_fq;
        lr     = line && !m_lq && frame;
        pop    = (mq.size() != 0) && ready && !fr;
        want   = valid && frame && (m_state == 2) && !fr;
        pushed = want && ((mq.size() < DEPTH) || pop);
        m_ovf  = (want && !pushed) || (m_ovf && !clr);
        m_udf  = (ready && (mq.size() == 0) && (m_state == 2) && line) || (m_udf && !clr);
        m_resync_n = 1;
        if (fr) begin
            mq.delete();
            m_frame = m_seen ? (m_frame + 1) % RESYNC : 0;
            if (m_frame == 0) m_resync_n = 0;
            m_seen = 1;
            m_lines = lr ? 1 : 0;
            m_state = (SKIPN == 0) ? 2 : 1;
            m_sof_pend = 1;
            m_sol_pend = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (pushed) begin
                e.pix = pix;
                e.sof = m_sof_pend;
                e.sol = m_sof_pend || m_sol_pend || lr;
                mq.push_back(e);
                m_sof_pend = 0;
                m_sol_pend = 0;
            end else if (lr) begin
                m_sol_pend = 1;
            end
            if (lr) begin
                if ((m_state == 1) && (m_lines >= SKIPN)) m_state = 2;
                if (m_lines < (1 << LINE_W) - 1) m_lines++;
            end
            if (ff) m_state = 0;
        end
        m_fq = frame;
        m_lq = line;
    endtask

    task automatic compare_all();
        check("level", 32'(fifo_level), 32'(mq.size()));
        check("valid", 32'(out_valid), 32'(mq.size() != 0));
        check("state", 32'(state), 32'(m_state));
        check("line_count", 32'(line_count), 32'(m_lines));
        check("frame_count", 32'(frame_count), 32'(m_frame));
        check("resync_n", 32'(resync_n), 32'(m_resync_n));
        check("ovf", 32'(ovf_sticky), 32'(m_ovf));
        check("udf", 32'(udf_sticky), 32'(m_udf));
        if (mq.size() != 0)
            check("head", 32'({out_sof, out_sol, out_pix}), 32'(mq[0]));
    endtask

    // One clock: record accepted pops, advance the model, then compare after the edge.
    task automatic tick();
        if (!reset && out_valid && ready && !(frame && !m_fq))
            got.push_back({out_sof, out_sol, out_pix});
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; frame = 1'b0; line = 1'b0; valid = 1'b0; ready = 1'b0; clr = 1'b0;
        pix = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_line(input int line_no, input int npix);
        line = 1'b1; valid = 1'b0;
        tick();
        for (int k = 0; k < npix; k++) begin
            valid = 1'b1;
            pix   = PIX_W'(line_no * 16 + k);
            tick();
        end
        valid = 1'b0; line = 1'b0;
        tick();
    endtask

    task automatic skip_to_active();
        for (int l = 1; l <= SKIPN; l++) do_line(l, 0);
        line = 1'b1; valid = 1'b0;
        tick();
    endtask

    typedef struct {
        bit frame; bit line; bit valid; bit ready; bit clr;
        int exp_level; int exp_state; int exp_lines; bit exp_resync_n; bit exp_udf;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 2, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 2, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 3, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 3, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 4, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 2, 4, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 2, 4, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 4, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 4, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 4, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1'b1, 1'b0};

        // Reset state
        do_reset();
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_resync_n", 32'(resync_n), 32'd1);
        check("rst_counts", 32'({line_count, frame_count}), 32'd0);
        check("rst_flags", 32'({out_valid, ovf_sticky, udf_sticky}), 32'd0);

        // Cycle table: skip three lines, push/pop, underflow, clear, frame fall
        for (int i = 0; i < 14; i++) begin
            frame = tbl[i].frame; line = tbl[i].line; valid = tbl[i].valid;
            ready = tbl[i].ready; clr = tbl[i].clr; pix = PIX_W'(i);
            tick();
            check("tbl_level", 32'(fifo_level), 32'(tbl[i].exp_level));
            check("tbl_state", 32'(state), 32'(tbl[i].exp_state));
            check("tbl_lines", 32'(line_count), 32'(tbl[i].exp_lines));
            check("tbl_resync_n", 32'(resync_n), 32'(tbl[i].exp_resync_n));
            check("tbl_udf", 32'(udf_sticky), 32'(tbl[i].exp_udf));
        end
        clr = 1'b0; ready = 1'b0;

        // T1: 5 lines x 8 px, three skipped -> 16 px with SOF/SOL tags
        do_reset();
        got.delete();
        ready = 1'b1; frame = 1'b1;
        tick();
        for (int l = 1; l <= 5; l++) do_line(l, 8);
        for (int i = 0; i < 3; i++) tick();
        check("t1_count", 32'(got.size()), 32'd16);
        foreach (got[i]) begin
            check("t1_pix", 32'(got[i].pix), 32'((4 + i / 8) * 16 + i % 8));
            check("t1_sof", 32'(got[i].sof), 32'(i == 0));
            check("t1_sol", 32'(got[i].sol), 32'(i % 8 == 0));
        end
        check("t1_lines", 32'(line_count), 32'd5);

        // T2: fill past full, clear, then push+pop on full
        ready = 1'b0; frame = 1'b0;
        tick();
        frame = 1'b1;
        tick();
        skip_to_active();
        for (int k = 0; k < DEPTH + 2; k++) begin
            valid = 1'b1; pix = PIX_W'(200 + k);
            tick();
        end
        check("t2_full_level", 32'(fifo_level), 32'(DEPTH));
        check("t2_ovf_set", 32'(ovf_sticky), 32'd1);
        valid = 1'b0; clr = 1'b1;
        tick();
        check("t2_ovf_clr", 32'(ovf_sticky), 32'd0);
        clr = 1'b0; valid = 1'b1; ready = 1'b1; pix = PIX_W'(24'h5a5a5a);
        tick();
        check("t2_pushpop_level", 32'(fifo_level), 32'(DEPTH));
        check("t2_pushpop_ovf", 32'(ovf_sticky), 32'd0);
        check("t2_head_advanced", 32'(out_pix), 32'd201);
        valid = 1'b0; ready = 1'b0;

        // T4: frame rise with three queued pixels flushes and rearms SOF
        frame = 1'b0; line = 1'b0;
        tick();
        frame = 1'b1;
        tick();
        skip_to_active();
        for (int k = 0; k < 3; k++) begin
            valid = 1'b1; pix = PIX_W'(300 + k);
            tick();
        end
        check("t4_level3", 32'(fifo_level), 32'd3);
        valid = 1'b0; frame = 1'b0; line = 1'b0;
        tick();
        frame = 1'b1; valid = 1'b1; ready = 1'b1;
        tick();
        check("t4_flush_level", 32'(fifo_level), 32'd0);
        check("t4_flush_valid", 32'(out_valid), 32'd0);
        check("t4_flush_ovf", 32'(ovf_sticky), 32'd0);
        valid = 1'b0; ready = 1'b0;
        skip_to_active();
        valid = 1'b1; pix = PIX_W'(24'habcdef);
        tick();
        valid = 1'b0;
        check("t4_sof_valid", 32'(out_valid), 32'd1);
        check("t4_sof_tags", 32'({out_sof, out_sol}), 32'd3);
        check("t4_sof_pix", 32'(out_pix), 32'h00abcdef);

        // T5: underflow mid-line in ACTIVE, set beats clear, ignored in SKIP
        ready = 1'b1;
        tick();
        tick();
        check("t5_udf_set", 32'(udf_sticky), 32'd1);
        clr = 1'b1;
        tick();
        check("t5_set_beats_clr", 32'(udf_sticky), 32'd1);
        ready = 1'b0;
        tick();
        check("t5_udf_clr", 32'(udf_sticky), 32'd0);
        clr = 1'b0; frame = 1'b0; line = 1'b0;
        tick();
        frame = 1'b1;
        tick();
        line = 1'b1; ready = 1'b1;
        tick();
        tick();
        tick();
        check("t5_skip_state", 32'(state), 32'd1);
        check("t5_skip_no_udf", 32'(udf_sticky), 32'd0);

        // T6: reset mid-line with ten queued pixels
        ready = 1'b0; line = 1'b0;
        tick();
        for (int l = 2; l <= SKIPN; l++) do_line(l, 0);
        line = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            valid = 1'b1; pix = PIX_W'(400 + k);
            tick();
        end
        check("t6_level10", 32'(fifo_level), 32'd10);
        reset = 1'b1;
        tick();
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_state", 32'(state), 32'd0);
        check("t6_counts", 32'({line_count, frame_count}), 32'd0);
        check("t6_resync_n", 32'(resync_n), 32'd1);
        check("t6_flags", 32'({out_valid, ovf_sticky, udf_sticky}), 32'd0);
        frame = 1'b0; line = 1'b0; valid = 1'b0;
        tick();
        reset = 1'b0;

        // T3: seven frames, frame_count wraps at 3, resync on rises 1, 4, 7
        do_reset();
        for (int i = 0; i < 7; i++) begin
            frame = 1'b1;
            tick();
            check("t3_frame_count", 32'(frame_count), 32'(i % 3));
            check("t3_resync_pulse", 32'(resync_n), 32'(i % 3 != 0));
            tick();
            check("t3_resync_idle", 32'(resync_n), 32'd1);
            frame = 1'b0;
            tick();
        end

        // line_count saturates at all-ones
        frame = 1'b1;
        tick();
        for (int l = 0; l < (1 << LINE_W) + 2; l++) begin
            line = 1'b1;
            tick();
            line = 1'b0;
            tick();
        end
        check("sat_lines", 32'(line_count), 32'((1 << LINE_W) - 1));
        frame = 1'b0;
        tick();

        // Randomized frames against the reference model
        for (int f = 0; f < 25; f++) begin
            int nl;
            frame = 1'b1; line = 1'b0; valid = 1'b0;
            tick();
            nl = int'($urandom_range(7, 3));
            for (int l = 0; l < nl; l++) begin
                int gap, len;
                gap = int'($urandom_range(3, 1));
                len = int'($urandom_range(14, 3));
                for (int g = 0; g < gap; g++) begin
                    line = 1'b0; valid = ($urandom % 4 == 0); pix = PIX_W'($urandom);
                    ready = ($urandom % 2 == 0); clr = ($urandom % 16 == 0);
                    tick();
                end
                for (int c = 0; c < len; c++) begin
                    line = 1'b1; valid = ($urandom % 4 != 0); pix = PIX_W'($urandom);
                    ready = ($urandom % 3 == 0); clr = ($urandom % 16 == 0);
                    tick();
                end
            end
            frame = 1'b0; line = 1'b0;
            for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
                valid = ($urandom % 2 == 0); ready = ($urandom % 2 == 0);
                clr = 1'b0;
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
